// File: rtl/operand_loader.sv
// operand_loader: ping-pong vector assembler feeding the dot-product stage.
// Optional LOADER_ZERO_PAD_EN adds in_last for short, zero-padded vectors.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module operand_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_w,
`ifdef LOADER_ZERO_PAD_EN
  input  logic                         in_last,
`endif
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic signed [DATA_WIDTH-1:0] x_out [N],
  output logic signed [DATA_WIDTH-1:0] w_out [N]
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic signed [DATA_WIDTH-1:0] xb [2][N];
  logic signed [DATA_WIDTH-1:0] wb [2][N];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] idx;
  logic          acc;
  logic          rel;
  logic          done;

  assign in_ready  = !full[wr_bank];
  assign vec_valid = full[rd_bank];
  assign acc       = in_valid && in_ready;
  assign rel       = vec_valid && vec_ready;

`ifdef LOADER_ZERO_PAD_EN
  assign done = (idx == IW'(N-1)) || in_last;
`else
  assign done = (idx == IW'(N-1));
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_out[i] = xb[rd_bank][i];
      w_out[i] = wb[rd_bank][i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          xb[b][i] <= '0;
          wb[b][i] <= '0;
        end
      end
    end else begin
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          if (IW'(i) == idx) begin
            xb[wr_bank][i] <= in_x;
            wb[wr_bank][i] <= in_w;
          end
`ifdef LOADER_ZERO_PAD_EN
          // short vector: clear stale lanes above the last beat
          else if (in_last && IW'(i) > idx) begin
            xb[wr_bank][i] <= '0;
            wb[wr_bank][i] <= '0;
          end
`endif
        end
        unique case (1'b1)
          done: begin
            idx           <= '0;
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
          end
          default: idx <= idx + IW'(1);
        endcase
      end
      // acc needs full[wr_bank]=0, rel needs full[rd_bank]=1: never same bit
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: random and directed stimulus vs a queue-based model.
// Model: list of completed vectors plus one partial vector.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_operand_loader;

  localparam int N  = 4;
  localparam int DW = `DATA_WIDTH;
`ifdef LOADER_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  typedef logic [N*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_w;
  logic in_last;
  logic vec_valid;
  logic vec_ready;
  logic signed [DW-1:0] x_out [N];
  logic signed [DW-1:0] w_out [N];

  int checks = 0;
  int errors = 0;

  vec_t mq_x[$];
  vec_t mq_w[$];
  vec_t px;
  vec_t pw;
  int   pcnt;

  always #5 clk = ~clk;

  operand_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_w(in_w),
`ifdef LOADER_ZERO_PAD_EN
    .in_last(in_last),
`endif
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .x_out(x_out),
    .w_out(w_out)
  );

  function automatic vec_t packx();
    vec_t r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = x_out[i];
    return r;
  endfunction

  function automatic vec_t packw();
    vec_t r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = w_out[i];
    return r;
  endfunction

  function automatic vec_t mk4(int a, int b, int c, int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic bit m_ready();
    return mq_x.size() < 2;
  endfunction

  function automatic bit m_valid();
    return mq_x.size() > 0;
  endfunction

  // One clock: drive at negedge, advance model at posedge, return at negedge
  task automatic cyc(input bit v, input int x, input int w,
                     input bit r, input bit l);
    bit acc;
    bit rel;
    in_valid  = v;
    in_x      = DW'(x);
    in_w      = DW'(w);
    vec_ready = r;
    in_last   = l;
    acc = v && m_ready();
    rel = r && m_valid();
    @(posedge clk);
    if (rst) begin
      mq_x.delete();
      mq_w.delete();
      px = '0;
      pw = '0;
      pcnt = 0;
    end else begin
      if (rel) begin
        void'(mq_x.pop_front());
        void'(mq_w.pop_front());
      end
      if (acc) begin
        px[pcnt*DW +: DW] = DW'(x);
        pw[pcnt*DW +: DW] = DW'(w);
        pcnt++;
        if (pcnt == N || (ZP && l)) begin
          mq_x.push_back(px);
          mq_w.push_back(pw);
          px = '0;
          pw = '0;
          pcnt = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_vec_valid got %b want 0", vec_valid);
    end
    checks++;
    if (packx() !== '0 || packw() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got x=%h w=%h want 0", packx(), packw());
    end
  endtask

  task automatic test_fill();
    int xs[4] = '{1, -2, 3, 4};
    int ws[4] = '{5, 6, -7, 8};
    int dp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, xs[i], ws[i], 1, 0);
      if (i < 3) begin
        checks++;
        if (vec_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_early_valid beat=%0d got %b want 0", i, vec_valid);
        end
      end
    end
    checks++;
    if (vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_valid got %b want 1", vec_valid);
    end
    checks++;
    if (packx() !== mk4(1, -2, 3, 4) || packw() !== mk4(5, 6, -7, 8)) begin
      errors++;
      $display("FAIL fill_data got x=%h w=%h want x=%h w=%h",
               packx(), packw(), mk4(1, -2, 3, 4), mk4(5, 6, -7, 8));
    end
    dp = 0;
    for (int i = 0; i < N; i++) dp += int'(x_out[i]) * int'(w_out[i]);
    checks++;
    if (dp !== 4) begin
      errors++;
      $display("FAIL fill_dot got %0d want 4", dp);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, i, 100 + i, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got %b want 0", in_ready);
    end
    cyc(1, 9, 109, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || packx() !== mk4(1, 2, 3, 4)) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b x=%h want rdy=0 x=%h",
               in_ready, packx(), mk4(1, 2, 3, 4));
    end
    cyc(0, 0, 0, 1, 0);
    checks++;
    if (in_ready !== 1'b1 || vec_valid !== 1'b1 ||
        packx() !== mk4(5, 6, 7, 8)) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b x=%h want 1 1 %h",
               in_ready, vec_valid, packx(), mk4(5, 6, 7, 8));
    end
    cyc(1, 9, 109, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || packx() !== mq_x[0]) begin
      errors++;
      $display("FAIL bp_beat9 got rdy=%b x=%h want 1 %h",
               in_ready, packx(), mq_x[0]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, i, -i, 0, 0);
    for (int i = 11; i <= 13; i++) cyc(1, i, -i, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || packx() !== mk4(1, 2, 3, 4)) begin
      errors++;
      $display("FAIL sim_setup got rdy=%b x=%h want 1 %h",
               in_ready, packx(), mk4(1, 2, 3, 4));
    end
    cyc(1, 14, -14, 1, 0);
    checks++;
    if (vec_valid !== 1'b1 || in_ready !== 1'b1 ||
        packx() !== mk4(11, 12, 13, 14) ||
        packw() !== mk4(-11, -12, -13, -14)) begin
      errors++;
      $display("FAIL sim_both got vld=%b rdy=%b x=%h want 1 1 %h",
               vec_valid, in_ready, packx(), mk4(11, 12, 13, 14));
    end
    for (int i = 21; i <= 24; i++) cyc(1, i, i, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || packx() !== mk4(11, 12, 13, 14)) begin
      errors++;
      $display("FAIL sim_refill got rdy=%b x=%h want 0 %h",
               in_ready, packx(), mk4(11, 12, 13, 14));
    end
    cyc(0, 0, 0, 1, 0);
    checks++;
    if (packx() !== mk4(21, 22, 23, 24)) begin
      errors++;
      $display("FAIL sim_bank0 got x=%h want %h", packx(), mk4(21, 22, 23, 24));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1, i, i, 0, 0);
    do_reset();
    checks++;
    if (vec_valid !== 1'b0 || in_ready !== 1'b1 ||
        packx() !== '0 || packw() !== '0) begin
      errors++;
      $display("FAIL rstmid got vld=%b rdy=%b x=%h w=%h want 0 1 0 0",
               vec_valid, in_ready, packx(), packw());
    end
    for (int i = 31; i <= 34; i++) cyc(1, i, -i, 0, 0);
    checks++;
    if (vec_valid !== 1'b1 || packx() !== mk4(31, 32, 33, 34) ||
        packw() !== mk4(-31, -32, -33, -34)) begin
      errors++;
      $display("FAIL rstmid_fresh got vld=%b x=%h want 1 %h",
               vec_valid, packx(), mk4(31, 32, 33, 34));
    end
  endtask

  task automatic test_extremes();
    int mn;
    int mx;
    vec_t ex;
    vec_t ew;
    mn = -(1 << (DW - 1));
    mx = (1 << (DW - 1)) - 1;
    for (int i = 0; i < N; i++) begin
      ex[i*DW +: DW] = DW'(mn);
      ew[i*DW +: DW] = DW'(mx);
    end
    do_reset();
    for (int i = 0; i < N; i++) cyc(1, mn, mx, 0, 0);
    checks++;
    if (vec_valid !== 1'b1 || packx() !== ex || packw() !== ew) begin
      errors++;
      $display("FAIL extremes got vld=%b x=%h w=%h want 1 %h %h",
               vec_valid, packx(), packw(), ex, ew);
    end
  endtask

`ifdef LOADER_ZERO_PAD_EN
  task automatic test_zero_pad();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, i, i, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 5; i <= 8; i++) cyc(1, i, i, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 9, 7, 0, 0);
    cyc(1, -9, -7, 0, 1);
    checks++;
    if (vec_valid !== 1'b1 || packx() !== mk4(9, -9, 0, 0) ||
        packw() !== mk4(7, -7, 0, 0)) begin
      errors++;
      $display("FAIL zpad got vld=%b x=%h w=%h want 1 %h %h",
               vec_valid, packx(), packw(), mk4(9, -9, 0, 0), mk4(7, -7, 0, 0));
    end
    cyc(0, 0, 0, 1, 0);
    for (int i = 41; i <= 44; i++) cyc(1, i, i, 0, 0);
    checks++;
    if (vec_valid !== 1'b1 || packx() !== mk4(41, 42, 43, 44)) begin
      errors++;
      $display("FAIL zpad_idx got x=%h want %h", packx(), mk4(41, 42, 43, 44));
    end
  endtask
`endif

  task automatic test_random();
    bit v;
    bit r;
    bit l;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      l = ZP && ($urandom_range(0, 5) == 0);
      cyc(v, int'($urandom), int'($urandom), r, l);
      checks++;
      if (in_ready !== m_ready() || vec_valid !== m_valid()) begin
        errors++;
        $display("FAIL rand_hs cyc=%0d got rdy=%b vld=%b want %b %b",
                 c, in_ready, vec_valid, m_ready(), m_valid());
      end
      if (m_valid()) begin
        checks++;
        if (packx() !== mq_x[0] || packw() !== mq_w[0]) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got x=%h w=%h want %h %h",
                   c, packx(), packw(), mq_x[0], mq_w[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    in_last = 1'b0;
    vec_ready = 1'b0;
    px = '0;
    pw = '0;
    pcnt = 0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_extremes();
`ifdef LOADER_ZERO_PAD_EN
    test_zero_pad();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
